// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one console UART transmit pin between two byte-stream requesters.
// A round-robin arbiter grants ownership to one requester at a time and keeps
// that ownership for a whole message. The message ends on a 0x0A byte, after
// MAX_BURST bytes, or after the owner has left valid low for IDLE_TIMEOUT
// cycles. An 8N1 serializer with a CLK_DIV baud divider drives the pin.
//
// Handshake: a byte moves on a rising CLK edge where reqN_valid && reqN_ready.
// reqN_ready is a pure function of registered state (owner and serializer
// idle); it never looks at valid. A requester may drop valid without a
// handshake. Data is sampled only on the accepting edge.
//
// Ports
//   CLK, RST_N               system clock, asynchronous active-low reset
//   req0_data/valid/ready    requester 0 byte stream
//   req1_data/valid/ready    requester 1 byte stream
//   grant [1:0]              one-hot owner (bit0 = req0, bit1 = req1), 00 = none
//   busy                     serializer is mid-frame
//   uart_SOUT                serial output, idles high
//   arb_state_dbg [1:0]      arbiter state (0 idle, 1 own0, 2 own1)
//   tx_state_dbg [1:0]       serializer state (0 idle, 1 start, 2 data, 3 stop)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int CLK_DIV      = 104,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       uart_SOUT,
    output logic [1:0] arb_state_dbg,
    output logic [1:0] tx_state_dbg
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [BW-1:0] BURST_LAST   = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    arb_state_t    arb_state;
    logic          last_owner;   // 0 = req0 owned last, 1 = req1 owned last
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] idle_cnt;

    tx_state_t     tx_state;
    logic [DW-1:0] bit_timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          sout_q;

    logic          tx_idle;
    logic          own_valid;
    logic [7:0]    own_data;
    logic          accept;
    logic          release_own;

    // ------------------------------------------------------------------
    // Combinational decode of registered state
    // ------------------------------------------------------------------
    assign tx_idle    = (tx_state == TX_IDLE);
    assign req0_ready = (arb_state == OWN0) && tx_idle;
    assign req1_ready = (arb_state == OWN1) && tx_idle;
    assign grant      = {arb_state == OWN1, arb_state == OWN0};
    assign busy       = !tx_idle;
    assign uart_SOUT  = sout_q;

    assign arb_state_dbg = arb_state;
    assign tx_state_dbg  = tx_state;

    assign own_valid = (arb_state == OWN1) ? req1_valid : req0_valid;
    assign own_data  = (arb_state == OWN1) ? req1_data  : req0_data;
    assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // A byte that is both 0x0A and the last of the burst gives one release.
    // A high owner valid always suppresses the timeout in that cycle.
    assign release_own = (arb_state != ARB_IDLE) &&
                         ((accept && (own_data == 8'h0A || burst_cnt == BURST_LAST)) ||
                          (!own_valid && idle_cnt == TIMEOUT_LAST));

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            arb_state  <= ARB_IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                    // On a tie the requester that did not own last wins.
                    if (req0_valid && (!req1_valid || last_owner)) begin
                        arb_state <= OWN0;
                    end else if (req1_valid) begin
                        arb_state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (release_own) begin
                        arb_state  <= ARB_IDLE;
                        last_owner <= (arb_state == OWN1);
                        burst_cnt  <= '0;
                        idle_cnt   <= '0;
                    end else begin
                        if (accept) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        if (own_valid) begin
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    arb_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // 8N1 serializer. bit_timer reloads to CLK_DIV-1 at every bit boundary,
    // so each bit is held for exactly CLK_DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state  <= TX_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            sout_q    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    sout_q <= 1'b1;
                    if (accept) begin
                        shift_reg <= own_data;
                        tx_state  <= TX_START;
                        sout_q    <= 1'b0;
                        bit_timer <= DIV_LAST;
                    end
                end
                TX_START: begin
                    if (bit_timer == '0) begin
                        tx_state  <= TX_DATA;
                        sout_q    <= shift_reg[0];
                        bit_idx   <= '0;
                        bit_timer <= DIV_LAST;
                    end else begin
                        bit_timer <= bit_timer - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_timer == '0) begin
                        bit_timer <= DIV_LAST;
                        if (bit_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            sout_q   <= 1'b1;
                        end else begin
                            // LSB first: the next bit is always at position 1.
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            sout_q    <= shift_reg[1];
                        end
                    end else begin
                        bit_timer <= bit_timer - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_timer == '0) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        bit_timer <= bit_timer - 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    sout_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Randomized and directed stimulus against a reference model that tracks
// ownership, per-message byte counts, owner idle time and the accept cycle
// of the frame in flight. Expected grant/ready/busy/pin values are derived
// from those with plain arithmetic every cycle. Accepted bytes are pushed to
// exp_q; a separate receiver decodes uart_SOUT and pops/compares.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int DIV = 4;
    localparam int MB  = 4;
    localparam int TO  = 8;

    logic       CLK;
    logic       RST_N;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] grant;
    logic       busy;
    logic       uart_SOUT;
    logic [1:0] arb_state_dbg;
    logic [1:0] tx_state_dbg;

    uart_tx_arbiter #(
        .CLK_DIV     (DIV),
        .MAX_BURST   (MB),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req0_data    (req0_data),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req1_data    (req1_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .grant        (grant),
        .busy         (busy),
        .uart_SOUT    (uart_SOUT),
        .arb_state_dbg(arb_state_dbg),
        .tx_state_dbg (tx_state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_owner;   // -1 none, 0 req0, 1 req1
    int         m_last;
    int         m_burst;
    int         m_idle;
    longint     m_cyc;
    longint     m_t;       // cycle in which the current frame's byte was accepted
    bit         m_tx_on;
    logic [7:0] m_byte;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_burst = 0;
        m_idle  = 0;
        m_tx_on = 1'b0;
        m_t     = 0;
        m_byte  = 8'h00;
        m_cyc   = 0;
    endtask

    function automatic bit m_tx_idle();
        return !(m_tx_on && m_cyc >= m_t + 1 && m_cyc <= m_t + 10 * DIV);
    endfunction

    function automatic logic m_sout();
        longint k;
        if (m_tx_idle()) return 1'b1;
        k = (m_cyc - m_t - 1) / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[int'(k) - 1];
    endfunction

    task automatic model_step();
        bit         v[2];
        logic [7:0] d[2];
        bit         acc;
        bit         rel;
        int         n;
        v[0] = req0_valid;
        v[1] = req1_valid;
        d[0] = req0_data;
        d[1] = req1_data;
        if (m_owner < 0) begin
            if (v[0] && v[1]) m_owner = 1 - m_last;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
        end else begin
            n   = m_owner;
            acc = v[n] && m_tx_idle();
            rel = 1'b0;
            if (acc) begin
                exp_q.push_back(d[n]);
                m_t     = m_cyc;
                m_tx_on = 1'b1;
                m_byte  = d[n];
                m_burst++;
                if (d[n] == 8'h0A || m_burst == MB) rel = 1'b1;
            end
            if (v[n]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) rel = 1'b1;
            end
            if (rel) begin
                m_last  = n;
                m_owner = -1;
                m_burst = 0;
                m_idle  = 0;
            end
        end
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RST_N) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                chk("grant", 32'(grant), {30'd0, m_owner == 1, m_owner == 0});
                chk("req0_ready", 32'(req0_ready), 32'(m_owner == 0 && m_tx_idle()));
                chk("req1_ready", 32'(req1_ready), 32'(m_owner == 1 && m_tx_idle()));
                chk("busy", 32'(busy), 32'(!m_tx_idle()));
                chk("sout", 32'(uart_SOUT), 32'(m_sout()));
            end
        end
    end

    // ---------------- UART receiver / scoreboard ----------------
    bit         rx_active = 1'b0;
    int         rx_cnt;
    logic [7:0] rx_byte;

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (uart_SOUT == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                for (int i = 0; i < 8; i++)
                    if (rx_cnt == DIV * (i + 1) + DIV / 2) rx_byte[i] = uart_SOUT;
                if (rx_cnt == DIV * 9 + DIV / 2) begin
                    chk("stop_bit", 32'(uart_SOUT), 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected got=%0h want=none", rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 32'(rx_byte), 32'(e));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int n, input logic [7:0] b, input int give_up);
        int waited = 0;
        bit hs;
        if (n == 0) begin req0_data = b; req0_valid = 1'b1; end
        else        begin req1_data = b; req1_valid = 1'b1; end
        forever begin
            @(negedge CLK);
            hs = (n == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
            @(posedge CLK);
            #1;
            if (hs) break;
            waited++;
            if (give_up != 0 && waited >= give_up) break;
            if (waited >= 3000) begin
                total++;
                bad++;
                $display("FAIL send_timeout req%0d got=no_accept want=accept", n);
                break;
            end
        end
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy || rx_active || grant != 2'b00) && n < 3000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        idle_cycles(2);
    endtask

    task automatic random_req(input int n);
        logic [7:0] b;
        int         give;
        for (int k = 0; k < 25; k++) begin
            idle_cycles($urandom_range(0, 30));
            b    = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            give = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
            send(n, b, give);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        RST_N      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_sout", 32'(uart_SOUT), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arb_state", 32'(arb_state_dbg), 32'd0);
        chk("rst_tx_state", 32'(tx_state_dbg), 32'd0);
        RST_N = 1'b1;

        // single byte
        idle_cycles(2);
        send(0, 8'h55, 0);
        drain();

        // two ties: req0 favoured first, then req0 again since req1 owned last
        for (int t = 0; t < 2; t++) begin
            fork
                begin send(0, 8'h41, 0); send(0, 8'h0A, 0); end
                begin send(1, 8'h42, 0); send(1, 8'h0A, 0); end
            join
            drain();
        end

        // burst limit forces hand-over to the waiting requester
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 8'(8'h30 + i), 0);
            end
            begin send(1, 8'h61, 0); send(1, 8'h0A, 0); end
        join
        drain();
        idle_cycles(TO + 2);

        // owner idle timeout while the other requester waits
        fork
            send(0, 8'h22, 0);
            begin idle_cycles(3); send(1, 8'h0A, 0); end
        join
        drain();

        // reset in the middle of data bit 2
        send(0, 8'hA5, 0);
        idle_cycles(13);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_sout", 32'(uart_SOUT), 32'd1);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        idle_cycles(2);
        send(0, 8'h3C, 0);
        drain();
        idle_cycles(TO + 2);

        // random traffic on both requesters
        fork
            random_req(0);
            random_req(1);
        join
        drain();
        idle_cycles(TO + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single SoC console UART transmit pin between two byte-stream requesters, for example the core's console path and an on-board debug/status source. Round-robin arbitration with message locking keeps lines from the two sources from interleaving. An integrated 8N1 serializer with a programmable baud divider drives the pin. It sits between the requesters and the top-level `uart_tx` pad of the FPGA wrapper.

## Interface
- `CLK_DIV`, default 104: clock cycles per UART bit (12 MHz / 115200); legal values are ≥ 2.
- `MAX_BURST`, default 64: maximum bytes per ownership before forced release; legal values are ≥ 1.
- `IDLE_TIMEOUT`, default 1024: consecutive cycles the owner's valid may stay low before forced release; legal values are ≥ 1.
- `CLK`  in  1  system clock; one clock domain only.
- `RST_N`  in  1  reset; asynchronous assertion, active-low.
- `req0_data`  in  8  byte from requester 0.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_ready`  out  1  byte accepted when `req0_valid && req0_ready`.
- `req1_data`, `req1_valid`, `req1_ready`: same as the requester 0 ports, for requester 1.
- `grant`  out  2  one-hot current owner; 2'b00 means no owner.
- `busy`  out  1  serializer is mid-frame.
- `uart_SOUT`  out  1  serial output; idles high.

## Operation
- Arbiter FSM states:
  - IDLE.
  - OWN0.
  - OWN1.
- IDLE:
  - If exactly one requester's valid is high, move to that requester's OWN state on the next cycle.
  - If both are high, grant the requester that did not own last. After reset, requester 0 is favoured.
- `readyN = (state==OWNN) && tx_idle`. It is a function of registered state only and never depends on valid.
- Only the owner's ready can be high. The non-owner's ready is always 0.
- An accepted byte is loaded into the shift register. The burst counter, of width clog2(MAX_BURST+1), increments on each accept and clears on entry to IDLE.
- Release from OWN to IDLE on the next cycle occurs on any of:
  - Acceptance of byte 0x0A.
  - Acceptance of the MAX_BURST-th byte.
  - The owner's valid being low for IDLE_TIMEOUT consecutive cycles. The timeout counter resets whenever the owner's valid is high.
- Release updates the last-owner record.
- Release may occur while the serializer is still sending. The next owner is granted normally but its ready stays low until `tx_idle`.
- A requester dropping valid without a handshake is legal. Data is only sampled on accept.
- Serializer FSM states:
  - TX_IDLE.
  - START.
  - DATA.
  - STOP.
- Serializer frame format:
  - 1 start bit at 0.
  - 8 data bits, LSB first.
  - 1 stop bit at 1.
  - Each bit is held for exactly CLK_DIV cycles, counted by a bit-timer that reloads at each bit boundary.
- `busy = !tx_idle`.

## Timing
- Reset values:
  - `uart_SOUT` = 1.
  - `req0_ready`, `req1_ready` = 0.
  - `grant` = 2'b00.
  - `busy` = 0.
  - Arbiter in IDLE with last-owner = 1, so requester 0 wins the first tie.
  - All counters = 0.
- Asserting reset mid-frame forces `uart_SOUT` high immediately and abandons the frame. No byte is replayed.
- Grant latency: valid seen in IDLE at cycle t gives `grant` and ready high at cycle t+1.
- Serializer timing for a byte accepted at cycle T:
  - Start bit occupies cycles T+1 to T+CLK_DIV.
  - Data bit i occupies cycles T+1+(i+1)·CLK_DIV to T+(i+2)·CLK_DIV.
  - Stop bit ends at cycle T+10·CLK_DIV.
  - `busy` is high from cycle T+1 to T+10·CLK_DIV.
- Back-to-back throughput: the next accept is possible at cycle T+10·CLK_DIV+1, giving one byte per 10·CLK_DIV+1 cycles.
- A release accept at cycle T sets `grant` to 00 at cycle T+1. A waiting requester is granted at cycle T+2.
- Simultaneous events:
  - If the last allowed byte is also 0x0A, there is a single release.
  - If the timeout expires in the same cycle that valid rises, valid wins and there is no release.

## Test plan
- Single byte: CLK_DIV=4, req0 sends 0x55 at reset-release+2.
  - `grant`=01 at the next cycle, one-cycle ready/valid accept.
  - `uart_SOUT` shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `busy` is high for exactly 40 cycles, then `req0_ready` returns to 1.
- Tie after reset:
  - Both requesters are valid in the same cycle and req0 sends "A\n" (0x41, 0x0A) → req0 is granted first, both bytes go out contiguously, then `grant`=00 for one cycle, then `grant`=10 and req1's bytes follow.
  - A second tie is then granted to req0, because req1 owned last.
- Burst limit: MAX_BURST=4, req0 streams 6 bytes with no 0x0A while req1 is valid → after the 4th accept, ownership passes to req1 and req0 resumes only after req1 releases.
- Timeout: IDLE_TIMEOUT=8, req0 sends 1 byte then holds valid low while req1 is valid → req0 releases 8 cycles after valid fell and req1 is granted. req1's ready rises only once the req0 frame completes (`busy`=0).
- Mid-frame reset: assert `RST_N`=0 during the 3rd data bit → `uart_SOUT`=1 and `grant`=00 immediately. After release the arbiter restarts in IDLE and a fresh byte transmits correctly.
- Ready protocol check: random valid toggling on both requesters → a non-owner's ready is never 1, no byte is accepted while `busy`=1, and every accepted byte appears on `uart_SOUT` exactly once.
